// File: rtl/mesh_wormhole_packetizer.sv
`default_nettype none
// mesh_wormhole_packetizer: wraps a tagged payload word stream into HEAD/BODY/TAIL
// wormhole flits for a mesh node TERM input through one registered output slot.
module mesh_wormhole_packetizer #(
  parameter int ROW_N     = 3,
  parameter int COL_M     = 3,
  parameter int CHANNEL_W = 8,
  parameter int FLIT_ID_W = 2,
  parameter int PKT_CNT_W = 8,
  localparam int ROW_ADDR_W  = $clog2(ROW_N),
  localparam int COL_ADDR_W  = $clog2(COL_M),
  localparam int FLIT_DATA_W = CHANNEL_W - FLIT_ID_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [FLIT_DATA_W-1:0] req_data_i,
  input  logic [ROW_ADDR_W-1:0]  req_dest_row_i,
  input  logic [COL_ADDR_W-1:0]  req_dest_col_i,
  input  logic                   req_last_i,
  input  logic                   req_vld_i,
  output logic                   req_rdy_o,
  output logic [CHANNEL_W-1:0]   out_data_o,
  output logic                   out_vld_o,
  input  logic                   out_rdy_i,
  output logic                   busy_o,
  output logic [PKT_CNT_W-1:0]   pkt_cnt_o,
  output logic                   dest_err_o
);

  localparam logic [1:0] ID_HEAD = 2'b01;
  localparam logic [1:0] ID_BODY = 2'b10;
  localparam logic [1:0] ID_TAIL = 2'b11;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PAYLOAD = 1'b1;

  // One extra bit so a non-power-of-two mesh size can be compared against
  localparam logic [ROW_ADDR_W:0] ROW_LIMIT = ROW_N[ROW_ADDR_W:0];
  localparam logic [COL_ADDR_W:0] COL_LIMIT = COL_M[COL_ADDR_W:0];

  logic [0:0]             state;
  logic [0:0]             state_nxt;
  logic                   slot_free;
  logic                   load;
  logic                   load_head;
  logic [CHANNEL_W-1:0]   load_flit;
  logic [FLIT_DATA_W-1:0] head_data;
  logic                   dest_bad;
  logic                   tail_handshake;

  assign slot_free = !out_vld_o || out_rdy_i;
  assign busy_o    = (state != S_IDLE) || out_vld_o;
  assign dest_bad  = ({1'b0, req_dest_row_i} >= ROW_LIMIT) ||
                     ({1'b0, req_dest_col_i} >= COL_LIMIT);
  assign tail_handshake = out_vld_o && out_rdy_i &&
                          (out_data_o[CHANNEL_W-1 -: 2] == ID_TAIL);

  always_comb begin
    head_data = '0;
    head_data[COL_ADDR_W-1:0]          = req_dest_col_i;
    head_data[COL_ADDR_W +: ROW_ADDR_W] = req_dest_row_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_vld_i && slot_free) begin
          state_nxt = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (req_vld_i && slot_free && req_last_i) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // HEAD is generated without consuming the first word, so req_rdy stays low in IDLE
  always_comb begin
    req_rdy_o = 1'b0;
    load      = 1'b0;
    load_head = 1'b0;
    load_flit = '0;
    case (state)
      S_IDLE: begin
        if (req_vld_i && slot_free) begin
          load      = 1'b1;
          load_head = 1'b1;
          load_flit = {ID_HEAD, head_data};
        end
      end
      S_PAYLOAD: begin
        req_rdy_o = slot_free;
        if (req_vld_i && slot_free) begin
          load      = 1'b1;
          load_flit = {(req_last_i ? ID_TAIL : ID_BODY), req_data_i};
        end
      end
      default: begin
        req_rdy_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_vld_o  <= 1'b0;
      out_data_o <= '0;
    end else if (load) begin
      out_vld_o  <= 1'b1;
      out_data_o <= load_flit;
    end else if (out_rdy_i) begin
      out_vld_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pkt_cnt_o  <= '0;
      dest_err_o <= 1'b0;
    end else begin
      if (tail_handshake) begin
        pkt_cnt_o <= pkt_cnt_o + 1'b1;
      end
      if (load_head && dest_bad) begin
        dest_err_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
